// File: rtl/noc_lfsr_traffic_gen_if.sv
// Flit link between a traffic source (master) and a router local port (slave).
// A flit moves on every rising edge where flit_valid and flit_ready are both high.
interface noc_lfsr_traffic_gen_if #(
  parameter int FLIT_W = 32
) ();

  logic [FLIT_W-1:0] flit_out;
  logic              flit_valid;
  logic              flit_ready;

  modport master (
    output flit_out,
    output flit_valid,
    input  flit_ready
  );

  modport slave (
    input  flit_out,
    input  flit_valid,
    output flit_ready
  );

endinterface : noc_lfsr_traffic_gen_if

// File: rtl/noc_lfsr_traffic_gen.sv
// noc_lfsr_traffic_gen
//   Pseudo-random packet source for a router local port. An XNOR Fibonacci LFSR
//   decides when to start a packet, picks its destination and fills its payload.
//   Packets of PKT_LEN flits leave over a valid/ready link, back-to-back within
//   a packet and with at least one idle cycle between packets.
//
//   Optional feature macro: TRAFFIC_STATS_EN adds saturating packet and stall
//   counters (ports pkt_cnt_o / stall_cnt_o). The datapath is the same either way.
//
//   Reset is synchronous and active-high.
module noc_lfsr_traffic_gen #(
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] SEED    = LFSR_W'(1),
  parameter int                FLIT_W  = 32,
  parameter int                DEST_W  = 4,
  parameter int                SRC_ID  = 0,
  parameter int                PKT_LEN = 4,
  parameter int                RATE_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable_i,
  input  logic [RATE_W-1:0]        inj_rate_i,
  input  logic                     seed_load_i,
  input  logic [LFSR_W-1:0]        seed_val_i,
  noc_lfsr_traffic_gen_if.master   link
`ifdef TRAFFIC_STATS_EN
  ,
  output logic [15:0]              pkt_cnt_o,
  output logic [15:0]              stall_cnt_o
`endif
);

  // Flit type codes carried in the two top bits of every flit.
  localparam logic [1:0] TYPE_BODY      = 2'b00;
  localparam logic [1:0] TYPE_HEAD      = 2'b01;
  localparam logic [1:0] TYPE_TAIL      = 2'b10;
  localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

  localparam int                PAY_W    = FLIT_W - 2;
  localparam int                IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PKT_LEN - 1);
  localparam logic [DEST_W-1:0] SRC      = DEST_W'(SRC_ID);
  localparam logic [1:0]        HEAD_TYPE = (PKT_LEN == 1) ? TYPE_HEAD_TAIL : TYPE_HEAD;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q,  lfsr_d;
  logic [FLIT_W-1:0]  flit_q,  flit_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [7:0]         seq_q,   seq_d;

  logic               feedback;
  logic               start;
  logic               xfer;
  logic               last_flit;
  logic [DEST_W-1:0]  dest;
  logic [FLIT_W-1:0]  head_flit;
  logic [PAY_W-1:0]   payload;
  logic [1:0]         next_type;

  // Feedback taps; only the branch matching LFSR_W is elaborated.
  if (LFSR_W == 8) begin : g_tap8
    assign feedback = ~(lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]);
  end else if (LFSR_W == 16) begin : g_tap16
    assign feedback = ~(lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]);
  end else begin : g_tap32
    assign feedback = ~(lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]);
  end

  assign xfer      = (state_q == SEND) && link.flit_ready;
  assign last_flit = (idx_q == LAST_IDX);
  // A seed load takes the cycle: the old LFSR value is about to be discarded.
  assign start     = (state_q == IDLE) && enable_i && !seed_load_i &&
                     (lfsr_q[RATE_W-1:0] < inj_rate_i);

  // LFSR next value: seed load wins over advance; an all-ones seed would lock
  // an XNOR LFSR, so it is replaced by zero.
  always_comb begin
    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    lfsr_d = lfsr_q;
    if (seed_load_i) begin
      lfsr_d = (&seed_val_i) ? '0 : seed_val_i;
    end else if (enable_i) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], feedback};
    end
  end

  // Head and payload flit images built from the current LFSR value.
  always_comb begin
    dest = lfsr_q[LFSR_W-1 -: DEST_W];
    if (dest == SRC) begin
      dest[0] = ~dest[0];
    end
    head_flit                                 = '0;
    head_flit[FLIT_W-1 -: 2]                  = HEAD_TYPE;
    head_flit[FLIT_W-3 -: DEST_W]             = dest;
    head_flit[FLIT_W-3-DEST_W -: DEST_W]      = SRC;
    head_flit[FLIT_W-3-2*DEST_W -: 8]         = seq_q;
    payload   = PAY_W'(lfsr_q);
    next_type = ((idx_q + IDX_W'(1)) == LAST_IDX) ? TYPE_TAIL : TYPE_BODY;
  end

  // Next-state logic of the packet FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)              state_d = SEND;
      SEND:    if (xfer && last_flit)  state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Flit register, flit index and sequence number updates per FSM state.
  always_comb begin
    flit_d = flit_q;
    idx_d  = idx_q;
    seq_d  = seq_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          flit_d = head_flit;
          idx_d  = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          if (last_flit) begin
            seq_d = seq_q + 8'd1;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            flit_d = {next_type, payload};
          end
        end
      end
      default: ;
    endcase
  end

  // State register for FSM, LFSR and flit datapath.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      flit_q  <= '0;
      idx_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      flit_q  <= flit_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
    end
  end

  assign link.flit_out   = flit_q;
  assign link.flit_valid = (state_q == SEND);

`ifdef TRAFFIC_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] stall_cnt_q;

  // Saturating counters of completed packets and back-pressured cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (xfer && last_flit && (pkt_cnt_q != 16'hFFFF)) begin
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
      if ((state_q == SEND) && !link.flit_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign pkt_cnt_o   = pkt_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule : noc_lfsr_traffic_gen
